// File: rtl/dm_access_unit_pkg.sv
// Shared encodings for the data-memory access stage:
// DMRe/DMWr codes, FSM states, size helpers.
package dm_access_unit_pkg;

  localparam logic [2:0] DMRE_NOP = 3'd0;
  localparam logic [2:0] DMRE_LB  = 3'd1;
  localparam logic [2:0] DMRE_LBU = 3'd2;
  localparam logic [2:0] DMRE_LH  = 3'd3;
  localparam logic [2:0] DMRE_LHU = 3'd4;
  localparam logic [2:0] DMRE_LW  = 3'd5;

  localparam logic [1:0] DMWR_NOP = 2'd0;
  localparam logic [1:0] DMWR_SB  = 2'd1;
  localparam logic [1:0] DMWR_SH  = 2'd2;
  localparam logic [1:0] DMWR_SW  = 2'd3;

  typedef enum logic [1:0] {
    DMA_IDLE = 2'd0,
    DMA_BUSY = 2'd1,
    DMA_DONE = 2'd2
  } dma_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  function automatic logic [1:0] acc_size(
    input logic       is_st,
    input logic [2:0] dmre,
    input logic [1:0] dmwr
  );
    logic [1:0] sz;
    sz = SZ_W;
    if (is_st) begin
      if (dmwr == DMWR_SB) sz = SZ_B;
      else if (dmwr == DMWR_SH) sz = SZ_H;
    end else begin
      if (dmre == DMRE_LB || dmre == DMRE_LBU)
        sz = SZ_B;
      else if (dmre == DMRE_LH || dmre == DMRE_LHU)
        sz = SZ_H;
    end
    return sz;
  endfunction

  function automatic logic [3:0] lane_be(
    input logic [1:0] sz,
    input logic [1:0] a
  );
    logic [3:0] be;
    be = 4'b1111;
    if (sz == SZ_B) be = 4'b0001 << a;
    else if (sz == SZ_H) be = a[1] ? 4'b1100 : 4'b0011;
    return be;
  endfunction

  function automatic logic [31:0] lane_rep(
    input logic [1:0]  sz,
    input logic [31:0] w
  );
    logic [31:0] r;
    r = w;
    if (sz == SZ_B) r = {4{w[7:0]}};
    else if (sz == SZ_H) r = {2{w[15:0]}};
    return r;
  endfunction

endpackage

// File: rtl/dm_access_unit_load_ext.sv
// dm_load_ext: picks the addressed lane of a read word and extends it.
// Ports: word (bus word), a (addr[1:0]), dmre (load type), res (result).
module dm_load_ext
  import dm_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  a,
  input  logic [2:0]  dmre,
  output logic [31:0] res
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = word[{a, 3'b000} +: 8];
  assign h = a[1] ? word[31:16] : word[15:0];

  always_comb begin
    res = word;
    unique case (dmre)
      DMRE_LB:  res = {{24{b[7]}}, b};
      DMRE_LBU: res = {24'd0, b};
      DMRE_LH:  res = {{16{h[15]}}, h};
      DMRE_LHU: res = {16'd0, h};
      default:  res = word;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// Data-memory access stage: stalls the core while a byte-enabled
// req/ack bus transfer runs, then returns the extended load result.
// Ports: clk, rst (sync, active-high); DMRe/DMWr/addr/wdata from decode
// and ALU; rdata/stall/bus_err/align_err to the core; mem_* bus.
// Optional macro DM_ALIGN_CHK_EN: trap misaligned half/word accesses.
module dm_access_unit
  import dm_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  DMRe,
  input  logic [1:0]  DMWr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        bus_err,
  output logic        align_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [8:0] TO9 = 9'(TIMEOUT_CYC);

  dma_state_e  state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic [2:0]  ld_q;
  logic        we_q, err_q;
  logic [7:0]  cnt_q;

  logic        is_st, is_ld, acc, mis;
  logic        busy, timeout;
  logic [1:0]  sz_in;
  logic [31:0] ext;

  // A store takes precedence over a simultaneous load.
  assign is_st = DMWr != DMWR_NOP;
  assign is_ld = !is_st
              && DMRe >= DMRE_LB
              && DMRe <= DMRE_LW;
  assign acc   = is_st | is_ld;
  assign sz_in = acc_size(is_st, DMRe, DMWr);

  assign busy    = state_q == DMA_BUSY;
  assign timeout = ({1'b0, cnt_q} + 9'd1) >= TO9;

`ifdef DM_ALIGN_CHK_EN
  logic aerr_q;

  assign mis = (sz_in == SZ_H && addr[0])
            || (sz_in == SZ_W && addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst)
      aerr_q <= 1'b0;
    else if (state_q == DMA_IDLE)
      aerr_q <= acc & mis;
  end

  assign align_err = (state_q == DMA_DONE) & aerr_q;
`else
  assign mis       = 1'b0;
  assign align_err = 1'b0;
`endif

  dm_load_ext u_ext (
    .word (mem_rdata),
    .a    (addr_q[1:0]),
    .dmre (ld_q),
    .res  (ext)
  );

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    mem_req = 1'b0;
    unique case (state_q)
      DMA_IDLE: begin
        if (acc) begin
          stall   = 1'b1;
          state_d = mis ? DMA_DONE : DMA_BUSY;
        end
      end
      DMA_BUSY: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ack || timeout)
          state_d = DMA_DONE;
      end
      DMA_DONE: state_d = DMA_IDLE;
      default:  state_d = DMA_IDLE;
    endcase
  end

  assign mem_we    = busy & we_q;
  assign mem_be    = busy ? be_q : 4'd0;
  assign mem_addr  = busy ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_wdata = busy ? wdata_q : 32'd0;
  assign bus_err   = (state_q == DMA_DONE) & err_q;
  assign rdata     = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DMA_IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      be_q    <= 4'd0;
      ld_q    <= DMRE_NOP;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        DMA_IDLE: begin
          if (acc) begin
            addr_q  <= addr;
            wdata_q <= lane_rep(sz_in, wdata);
            be_q    <= lane_be(sz_in, addr[1:0]);
            ld_q    <= is_st ? DMRE_NOP : DMRe;
            we_q    <= is_st;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
            if (mis)
              rdata_q <= 32'd0;
          end
        end
        DMA_BUSY: begin
          if (mem_ack) begin
            if (!we_q)
              rdata_q <= ext;
          end else begin
            if (cnt_q != 8'hFF)
              cnt_q <= cnt_q + 8'd1;
            if (timeout) begin
              err_q   <= 1'b1;
              rdata_q <= 32'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
